imem_load_run_ctrl: RTL

IMEM_LOAD_RUN_CTRL -- requirements
Module: imem_load_run_ctrl

---
 rtl/imem_load_run_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_load_run_ctrl.sv
// imem_load_run_ctrl
// Session controller that holds the core in reset, clears its memory, streams
// host instruction words into the core's instruction memory, then releases the
// core and lets it run for a bounded (or stop-terminated) number of cycles.
// Core-facing strobes and levels are registered from the next state so they
// line up with the state they belong to.

module imem_load_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              instruction_write,
    output logic [ADDR_W-1:0] instruction_addr,
    output logic [DATA_W-1:0] instruction_data,
    output logic              core_reset_n,
    output logic              mem_reset_n,
    output logic              run_pc,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic [CNT_W-1:0]    rc_q, rc_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                mem_rst_n_q, mem_rst_n_d;
    logic                run_pc_q, run_pc_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                start_ok_s;
    logic                beat_s;
    logic                last_beat_s;

    // Legal word counts are 1..2^ADDR_W; anything else leaves the block idle.
    assign start_ok_s  = (word_count != {(ADDR_W+1){1'b0}}) &&
                         (!word_count[ADDR_W] || (word_count[ADDR_W-1:0] == {ADDR_W{1'b0}}));
    // A stop in LOAD wins over a simultaneous beat, so the beat is dropped.
    assign beat_s      = (state_q == ST_LOAD) && s_valid && !stop;
    assign last_beat_s = ({1'b0, idx_q} == (wc_q - (ADDR_W+1)'(1)));

    assign s_ready = (state_q == ST_LOAD);
    assign busy    = (state_q != ST_IDLE);

    // Session sequencing: next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && start_ok_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (beat_s && last_beat_s) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: session parameters, word index, run counter, write port and core controls.
    always_comb begin
        wc_d         = wc_q;
        rc_d         = rc_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        wr_d         = beat_s;
        addr_d       = addr_q;
        data_d       = data_q;
        core_rst_n_d = 1'b0;
        mem_rst_n_d  = 1'b1;
        run_pc_d     = 1'b0;
        done_d       = 1'b0;
        aborted_d    = (state_q == ST_LOAD) && stop;

        if ((state_q == ST_IDLE) && start && start_ok_s) begin
            wc_d = word_count;
            rc_d = run_cycles;
        end else begin
            wc_d = wc_q;
            rc_d = rc_q;
        end

        // Index restarts in CLEAR and holds on the final beat so it never wraps.
        if (state_q == ST_CLEAR) begin
            idx_d = {ADDR_W{1'b0}};
        end else if (beat_s && !last_beat_s) begin
            idx_d = idx_q + ADDR_W'(1);
        end else begin
            idx_d = idx_q;
        end

        if (beat_s) begin
            addr_d = idx_q;
            data_d = s_data;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end

        // RUN is only ever entered from RELEASE, so the count loads there;
        // a zero count parks at zero and only stop ends the run.
        if (state_q == ST_RELEASE) begin
            cnt_d = rc_q;
        end else if ((state_q == ST_RUN) && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_d)
            ST_IDLE: begin
                core_rst_n_d = 1'b0;
                mem_rst_n_d  = 1'b1;
            end
            ST_CLEAR: begin
                core_rst_n_d = 1'b0;
                mem_rst_n_d  = 1'b0;
            end
            ST_LOAD: begin
                core_rst_n_d = 1'b0;
                mem_rst_n_d  = 1'b1;
            end
            ST_RELEASE: begin
                core_rst_n_d = 1'b1;
                mem_rst_n_d  = 1'b1;
            end
            ST_RUN: begin
                core_rst_n_d = 1'b1;
                mem_rst_n_d  = 1'b1;
                run_pc_d     = 1'b1;
            end
            ST_FINISH: begin
                core_rst_n_d = 1'b1;
                mem_rst_n_d  = 1'b1;
                done_d       = 1'b1;
            end
            default: begin
                core_rst_n_d = 1'b0;
                mem_rst_n_d  = 1'b1;
            end
        endcase
    end

    // State and registered-output update; reset abandons any session silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wc_q         <= {(ADDR_W+1){1'b0}};
            rc_q         <= {CNT_W{1'b0}};
            idx_q        <= {ADDR_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            wr_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            core_rst_n_q <= 1'b0;
            mem_rst_n_q  <= 1'b0;
            run_pc_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            rc_q         <= rc_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_rst_n_q <= core_rst_n_d;
            mem_rst_n_q  <= mem_rst_n_d;
            run_pc_q     <= run_pc_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign instruction_write = wr_q;
    assign instruction_addr  = addr_q;
    assign instruction_data  = data_q;
    assign core_reset_n      = core_rst_n_q;
    assign mem_reset_n       = mem_rst_n_q;
    assign run_pc            = run_pc_q;
    assign done              = done_q;
    assign aborted           = aborted_q;

endmodule
